snake_body_mover: RTL and testbench

- Upstream neighbour of the apple/growth stage: owns the snake body, advances it one grid cell per move period, and drives head_x/head_y into the apple stage.
- Consumes that stage's add_cube pulse to lengthen the body.
- Detects wall and self collision, and provides a per-pixel-cell body hit query for the VGA renderer.
- Playfield cells: x 1..38, y 1..28. Cells x=0, x=39, y=0, y=29 are walls.

---
 rtl/snake_body_mover.sv | 173 +++++++++++++++++
 tb/tb_snake_body_mover.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_mover.sv
// Snake body register file: advances the body one cell per move period,
// handles growth requests, wall/self collision and the renderer body query.
module snake_body_mover #(
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 3,
    parameter int MOVE_TICKS = 12_500_000,
    parameter int X_MAX      = 38,
    parameter int Y_MAX      = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_dir,
    input  logic       add_cube,
    input  logic [5:0] query_x,
    input  logic [5:0] query_y,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [4:0] snake_len,
    output logic       is_body,
    output logic       move_tick,
    output logic       game_over,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    // Encoding chosen so that the reverse direction is dir ^ 1.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [4:0]  LEN_MAX  = 5'(MAX_LEN);
    localparam logic [4:0]  LEN_INIT = 5'(INIT_LEN);
    localparam logic [31:0] CNT_LAST = 32'(MOVE_TICKS - 1);
    localparam logic [5:0]  WALL_X   = 6'(X_MAX + 1);
    localparam logic [5:0]  WALL_Y   = 6'(Y_MAX + 1);

    logic [1:0]  r_state;
    logic [1:0]  r_dir;
    logic [1:0]  r_next_dir;
    logic [31:0] r_cnt;
    logic [5:0]  r_seg_x [MAX_LEN];
    logic [5:0]  r_seg_y [MAX_LEN];
    logic [4:0]  r_len;
    logic        r_grow;
    logic        r_move_tick;

    logic        w_key_valid;
    logic [1:0]  w_key_dir;
    logic        w_key_ok;
    logic        w_step;
    logic [5:0]  w_new_x;
    logic [5:0]  w_new_y;
    logic        w_wall;
    logic        w_grow_eff;
    logic [4:0]  w_cmp_len;
    logic        w_self;
    logic        w_is_body;

    always_comb begin
        w_key_valid = |key_dir;
        w_key_dir   = DIR_RIGHT;
        if (key_dir[3])      w_key_dir = DIR_UP;
        else if (key_dir[2]) w_key_dir = DIR_DOWN;
        else if (key_dir[1]) w_key_dir = DIR_LEFT;
        // Rejecting the reverse of the pending direction too stops two keys
        // in one period from folding the head back onto the neck.
        w_key_ok = w_key_valid
                && (w_key_dir != (r_dir ^ 2'b01))
                && (w_key_dir != (r_next_dir ^ 2'b01));
    end

    assign w_step = (r_state == ST_MOVING) && (r_cnt == CNT_LAST);

    always_comb begin
        w_new_x = r_seg_x[0];
        w_new_y = r_seg_y[0];
        case (r_next_dir)
            DIR_UP:    w_new_y = r_seg_y[0] - 6'd1;
            DIR_DOWN:  w_new_y = r_seg_y[0] + 6'd1;
            DIR_LEFT:  w_new_x = r_seg_x[0] - 6'd1;
            default:   w_new_x = r_seg_x[0] + 6'd1;
        endcase
    end

    assign w_wall = (w_new_x == 6'd0) || (w_new_x == WALL_X)
                 || (w_new_y == 6'd0) || (w_new_y == WALL_Y);

    // At full length the tail still vacates, so it is excluded like a plain move.
    assign w_grow_eff = r_grow && (r_len < LEN_MAX);
    assign w_cmp_len  = w_grow_eff ? r_len : (r_len - 5'd1);

    always_comb begin
        w_self = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < w_cmp_len) && (r_seg_x[i] == w_new_x) && (r_seg_y[i] == w_new_y))
                w_self = 1'b1;
        end
    end

    always_comb begin
        w_is_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < r_len) && (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y))
                w_is_body = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_dir       <= DIR_RIGHT;
            r_next_dir  <= DIR_RIGHT;
            r_cnt       <= 32'd0;
            r_len       <= LEN_INIT;
            r_grow      <= 1'b0;
            r_move_tick <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i < INIT_LEN) ? 6'(5 - i) : 6'd0;
                r_seg_y[i] <= (i < INIT_LEN) ? 6'd5 : 6'd0;
            end
        end else begin
            r_move_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_valid) begin
                        r_state <= ST_MOVING;
                        if (w_key_ok) r_next_dir <= w_key_dir;
                    end
                end
                ST_MOVING: begin
                    if (w_key_ok) r_next_dir <= w_key_dir;
                    if (w_step) begin
                        r_cnt <= 32'd0;
                        if (w_wall || w_self) begin
                            r_state <= ST_DEAD;
                        end else begin
                            r_dir       <= r_next_dir;
                            r_move_tick <= 1'b1;
                            r_seg_x[0]  <= w_new_x;
                            r_seg_y[0]  <= w_new_y;
                            for (int i = 1; i < MAX_LEN; i++) begin
                                r_seg_x[i] <= r_seg_x[i-1];
                                r_seg_y[i] <= r_seg_y[i-1];
                            end
                            if (w_grow_eff) r_len <= r_len + 5'd1;
                            // A request landing in the step cycle carries to the next step.
                            r_grow <= add_cube;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                        if (add_cube) r_grow <= 1'b1;
                    end
                end
                ST_DEAD: begin
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign snake_len = r_len;
    assign is_body   = w_is_body;
    assign move_tick = r_move_tick;
    assign game_over = (r_state == ST_DEAD);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_snake_body_mover.sv
// Directed bench for snake_body_mover with a 4-cycle move period.
module tb_snake_body_mover;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_dir = 4'd0;
  logic       add_cube = 1'b0;
  logic [5:0] query_x = 6'd0;
  logic [5:0] query_y = 6'd0;
  logic [5:0] head_x, head_y;
  logic [4:0] snake_len;
  logic       is_body, move_tick, game_over;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int n;

  snake_body_mover #(.MOVE_TICKS(4)) dut (
    .clk(clk), .rst(rst), .key_dir(key_dir), .add_cube(add_cube),
    .query_x(query_x), .query_y(query_y), .head_x(head_x), .head_y(head_y),
    .snake_len(snake_len), .is_body(is_body), .move_tick(move_tick),
    .game_over(game_over), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    key_dir = 4'd0;
    add_cube = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic press(input logic [3:0] k);
    key_dir = k;
    tick;
    key_dir = 4'd0;
  endtask

  task automatic pulse_add;
    add_cube = 1'b1;
    tick;
    add_cube = 1'b0;
  endtask

  task automatic wait_tick(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick;
      cycles++;
    end while (!move_tick && cycles < 40);
    check({tag, "_tick"}, 32'(move_tick), 1);
  endtask

  task automatic check_head(input string tag, input int x, input int y);
    check({tag, "_hx"}, 32'(head_x), x);
    check({tag, "_hy"}, 32'(head_y), y);
  endtask

  task automatic body_at(input string tag, input int x, input int y, input int exp);
    query_x = 6'(x);
    query_y = 6'(y);
    #1;
    check(tag, 32'(is_body), exp);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick;
      if (move_tick) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    // reset and idle
    repeat (2) tick;
    check_head("rst", 5, 5);
    check("rst_len", 32'(snake_len), 3);
    check("rst_go", 32'(game_over), 0);
    check("rst_tick", 32'(move_tick), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b1;
    tick;
    quiet("idle_quiet", 100);
    check_head("idle", 5, 5);
    check("idle_state", 32'(dbg_state), 0);

    // moving right, period and body query
    press(4'b0001);
    check("mv_state", 32'(dbg_state), 1);
    wait_tick("s1", n);
    check("s1_period", n, 4);
    check_head("s1", 6, 5);
    body_at("s1_b45", 4, 5, 1);
    wait_tick("s2", n);
    check("s2_period", n, 4);
    check_head("s2", 7, 5);
    body_at("s2_b55", 5, 5, 1);
    body_at("s2_b45", 4, 5, 0);
    wait_tick("s3", n);
    check("s3_period", n, 4);
    check_head("s3", 8, 5);
    body_at("s3_b65", 6, 5, 1);
    body_at("s3_b55", 5, 5, 0);
    body_at("s3_b85", 8, 5, 1);
    tick;
    check("tick_pulse_width", 32'(move_tick), 0);

    // reverse key ignored; up then down in one period keeps up
    press(4'b0010);
    wait_tick("rev", n);
    check_head("rev", 9, 5);
    press(4'b1000);
    tick;
    press(4'b0100);
    wait_tick("ud", n);
    check_head("ud", 9, 4);
    wait_tick("ud2", n);
    check_head("ud2", 9, 3);

    // growth, merge of pulses, saturation at 16
    do_reset;
    check_head("rst2", 5, 5);
    check("rst2_len", 32'(snake_len), 3);
    pulse_add;
    press(4'b0001);
    wait_tick("g0", n);
    check_head("g0", 6, 5);
    check("idle_add_len", 32'(snake_len), 3);
    pulse_add;
    tick;
    pulse_add;
    wait_tick("g1", n);
    check_head("g1", 7, 5);
    check("merge_len", 32'(snake_len), 4);
    wait_tick("g2", n);
    check("nogrow_len", 32'(snake_len), 4);
    for (int i = 0; i < 12; i++) begin
      pulse_add;
      wait_tick("gl", n);
    end
    check_head("gfull", 20, 5);
    check("full_len", 32'(snake_len), 16);
    pulse_add;
    wait_tick("gsat", n);
    check_head("gsat", 21, 5);
    check("sat_len", 32'(snake_len), 16);
    body_at("sat_b65", 6, 5, 1);
    body_at("sat_b55", 5, 5, 0);

    // wall collision at the top edge
    do_reset;
    press(4'b1000);
    wait_tick("w1", n);
    check_head("w1", 5, 4);
    wait_tick("w2", n);
    wait_tick("w3", n);
    wait_tick("w4", n);
    check_head("w4", 5, 1);
    quiet("wall_quiet", 8);
    check("wall_go", 32'(game_over), 1);
    check("wall_state", 32'(dbg_state), 2);
    check_head("wall", 5, 1);
    press(4'b0001);
    quiet("dead_quiet", 8);
    check_head("dead", 5, 1);
    body_at("dead_b51", 5, 1, 1);
    body_at("dead_b52", 5, 2, 1);
    body_at("dead_b54", 5, 4, 0);
    rst = 1'b0;
    #1;
    check_head("async_rst", 5, 5);
    check("async_rst_go", 32'(game_over), 0);
    rst = 1'b1;
    tick;

    // self collision after growing to 5
    do_reset;
    press(4'b0001);
    pulse_add;
    wait_tick("c1", n);
    pulse_add;
    wait_tick("c2", n);
    check_head("c2", 7, 5);
    check("c2_len", 32'(snake_len), 5);
    wait_tick("cr", n);
    check_head("cr", 8, 5);
    press(4'b0100);
    wait_tick("cd", n);
    check_head("cd", 8, 6);
    press(4'b0010);
    wait_tick("cl", n);
    check_head("cl", 7, 6);
    press(4'b1000);
    quiet("self_quiet", 8);
    check("self_go", 32'(game_over), 1);
    check_head("self", 7, 6);
    check("self_len", 32'(snake_len), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
